// File: rtl/elevator_car_drive.sv
// rtl/elevator_car_drive.sv - behavioural car/shaft drive for one elevator car
//
// Moves the car one floor per travel segment on the 2-bit motor command and
// runs the door open/hold/close timing. All outputs are registered.
//
// Optional feature macro: ELEVATOR_FLOOR_ONEHOT_EN adds floor_onehot.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   motor_signal  00 stop, 01 up, 10 down, 11 open door
//   cur_floor     current floor index
//   moving        car is inside a travel segment
//   dir_up        direction of the current or last segment (1 = up)
//   arrived       one-cycle pulse when cur_floor changes
//   door_open     door is open
//   limit_fault   one-cycle pulse when a move would leave the shaft
//   floor_onehot  1 << cur_floor (only with ELEVATOR_FLOOR_ONEHOT_EN)
`timescale 1ns/1ps

module elevator_car_drive #(
  parameter int NUM_FLOORS    = 11,
  parameter int FLOOR_W       = 4,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 16,
  parameter int RESET_FLOOR   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         motor_signal,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic               moving,
  output logic               dir_up,
  output logic               arrived,
  output logic               door_open,
  output logic               limit_fault
`ifdef ELEVATOR_FLOOR_ONEHOT_EN
  ,
  output logic [NUM_FLOORS-1:0] floor_onehot
`endif
);

  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W-1:0] RST_FLOOR   = FLOOR_W'(RESET_FLOOR);
  localparam logic [15:0]        TRAVEL_LOAD = 16'(TRAVEL_CYCLES - 1);
  localparam logic [15:0]        DOOR_LOAD   = 16'(DOOR_CYCLES - 1);

  localparam logic [1:0] CMD_UP   = 2'b01;
  localparam logic [1:0] CMD_DOWN = 2'b10;
  localparam logic [1:0] CMD_DOOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  state_t              state;
  logic [15:0]         cnt;    // shared by MOVE (travel) and DOOR (hold time)
  logic [FLOOR_W-1:0]  next_floor;
  logic                run_on;

  // Floor reached at the end of the current segment, and whether the car
  // keeps going: same-direction command and the new floor is not the end
  // of the shaft in that direction.
  always_comb begin
    next_floor = dir_up ? cur_floor + FLOOR_W'(1) : cur_floor - FLOOR_W'(1);
    run_on     = 1'b0;
    if (dir_up) begin
      run_on = (motor_signal == CMD_UP) && (next_floor != TOP_FLOOR);
    end else begin
      run_on = (motor_signal == CMD_DOWN) && (next_floor != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cur_floor   <= RST_FLOOR;
      moving      <= 1'b0;
      dir_up      <= 1'b1;
      arrived     <= 1'b0;
      door_open   <= 1'b0;
      limit_fault <= 1'b0;
    end else begin
      arrived     <= 1'b0;
      limit_fault <= 1'b0;
      case (state)
        IDLE: begin
          case (motor_signal)
            CMD_UP: begin
              if (cur_floor < TOP_FLOOR) begin
                state  <= MOVE;
                moving <= 1'b1;
                dir_up <= 1'b1;
                cnt    <= TRAVEL_LOAD;
              end else begin
                limit_fault <= 1'b1;
              end
            end
            CMD_DOWN: begin
              if (cur_floor != '0) begin
                state  <= MOVE;
                moving <= 1'b1;
                dir_up <= 1'b0;
                cnt    <= TRAVEL_LOAD;
              end else begin
                limit_fault <= 1'b1;
              end
            end
            CMD_DOOR: begin
              state     <= DOOR;
              door_open <= 1'b1;
              cnt       <= DOOR_LOAD;
            end
            default: ;
          endcase
        end

        // The command only matters on the edge that completes a segment,
        // so a segment can never reverse mid-shaft.
        MOVE: begin
          if (cnt != '0) begin
            cnt <= cnt - 16'd1;
          end else begin
            cur_floor <= next_floor;
            arrived   <= 1'b1;
            if (run_on) begin
              cnt <= TRAVEL_LOAD;
            end else begin
              state  <= IDLE;
              moving <= 1'b0;
            end
          end
        end

        DOOR: begin
          if (motor_signal == CMD_DOOR) begin
            cnt <= DOOR_LOAD;
          end else if (cnt != '0) begin
            cnt <= cnt - 16'd1;
          end else begin
            state     <= IDLE;
            door_open <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef ELEVATOR_FLOOR_ONEHOT_EN
  localparam logic [NUM_FLOORS-1:0] ONE_HOT_LSB = NUM_FLOORS'(1);

  // Tracks cur_floor on exactly the same edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      floor_onehot <= ONE_HOT_LSB << RESET_FLOOR;
    end else if (state == MOVE && cnt == '0) begin
      floor_onehot <= ONE_HOT_LSB << next_floor;
    end
  end
`else
  // One-hot floor output not built.
`endif

endmodule

// File: tb/tb_elevator_car_drive.sv
// tb/tb_elevator_car_drive.sv - directed self-checking bench for elevator_car_drive
`timescale 1ns/1ps

module tb_elevator_car_drive;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] motor_signal;
  logic [3:0] cur_floor;
  logic       moving;
  logic       dir_up;
  logic       arrived;
  logic       door_open;
  logic       limit_fault;
`ifdef ELEVATOR_FLOOR_ONEHOT_EN
  logic [10:0] floor_onehot;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  elevator_car_drive dut (
    .clk          (clk),
    .rst          (rst),
    .motor_signal (motor_signal),
    .cur_floor    (cur_floor),
    .moving       (moving),
    .dir_up       (dir_up),
    .arrived      (arrived),
    .door_open    (door_open),
    .limit_fault  (limit_fault)
`ifdef ELEVATOR_FLOOR_ONEHOT_EN
    ,
    .floor_onehot (floor_onehot)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply a command, let one rising edge sample it, then settle 1 ns.
  task automatic tick(input logic [1:0] c);
    motor_signal = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    motor_signal = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_floor", cur_floor, 0);
    chk("rst_moving", moving, 0);
    chk("rst_door", door_open, 0);
    chk("rst_arrived", arrived, 0);
    chk("rst_limit", limit_fault, 0);
    chk("rst_dir", dir_up, 1);
`ifdef ELEVATOR_FLOOR_ONEHOT_EN
    chk("rst_onehot", floor_onehot, 11'b00000000001);
`endif

    // Down at floor 0: fault pulse, direction unchanged
    tick(2'b10);
    chk("lim0_fault", limit_fault, 1);
    chk("lim0_moving", moving, 0);
    chk("lim0_dir", dir_up, 1);
    tick(2'b00);
    chk("lim0_fault_clr", limit_fault, 0);

    // Single floor up: 01 at E0 then 00
    tick(2'b01);
    chk("up1_moving_e0", moving, 1);
    chk("up1_dir", dir_up, 1);
    for (int i = 1; i <= 7; i++) begin
      tick(2'b00);
      chk("up1_moving", moving, 1);
      chk("up1_floor_hold", cur_floor, 0);
      chk("up1_no_arrive", arrived, 0);
    end
    tick(2'b00);
    chk("up1_floor", cur_floor, 1);
    chk("up1_arrived", arrived, 1);
    chk("up1_stopped", moving, 0);
`ifdef ELEVATOR_FLOOR_ONEHOT_EN
    chk("up1_onehot", floor_onehot, 11'b00000000010);
`endif
    tick(2'b00);
    chk("up1_arrived_clr", arrived, 0);

    // Down 1->0 with 01 applied mid-segment: ignored, then IDLE, then up
    tick(2'b10);
    chk("rev_moving", moving, 1);
    chk("rev_dir_down", dir_up, 0);
    for (int i = 1; i <= 7; i++) begin
      tick(2'b01);
      chk("rev_still_moving", moving, 1);
      chk("rev_dir_hold", dir_up, 0);
    end
    tick(2'b01);
    chk("rev_floor0", cur_floor, 0);
    chk("rev_arrived", arrived, 1);
    chk("rev_idle_gap", moving, 0);
    chk("rev_no_fault", limit_fault, 0);
    tick(2'b01);
    chk("rev_up_start", moving, 1);
    chk("rev_up_dir", dir_up, 1);
    for (int i = 1; i <= 7; i++) tick(2'b00);
    tick(2'b00);
    chk("rev_up_floor1", cur_floor, 1);

    // Back down to floor 0
    tick(2'b10);
    for (int i = 1; i <= 7; i++) tick(2'b00);
    tick(2'b00);
    chk("down_floor0", cur_floor, 0);
    chk("down_stopped", moving, 0);

    // Run-through up with 01 held
    tick(2'b01);
    for (int f = 1; f <= 10; f++) begin
      for (int i = 1; i <= 7; i++) begin
        tick(2'b01);
        chk("run_moving", moving, 1);
        chk("run_no_arrive", arrived, 0);
      end
      tick(2'b01);
      chk("run_floor", cur_floor, f);
      chk("run_arrived", arrived, 1);
      chk("run_moving_after", moving, (f < 10) ? 1 : 0);
      chk("run_no_fault", limit_fault, 0);
    end
`ifdef ELEVATOR_FLOOR_ONEHOT_EN
    chk("run_onehot", floor_onehot, 11'b10000000000);
`endif
    tick(2'b01);
    chk("top_fault", limit_fault, 1);
    chk("top_floor", cur_floor, 10);
    chk("top_moving", moving, 0);
    tick(2'b00);
    chk("top_fault_clr", limit_fault, 0);

    // Door hold: 11 at E0, 01 during door, 11 again at E10
    tick(2'b11);
    chk("door_open_e0", door_open, 1);
    chk("door_moving_e0", moving, 0);
    for (int i = 1; i <= 9; i++) begin
      tick(2'b01);
      chk("door_open_early", door_open, 1);
      chk("door_moving", moving, 0);
    end
    tick(2'b11);
    chk("door_hold_e10", door_open, 1);
    for (int i = 11; i <= 25; i++) begin
      tick(2'b00);
      chk("door_open_held", door_open, 1);
      chk("door_moving_held", moving, 0);
    end
    tick(2'b00);
    chk("door_closed", door_open, 0);
    chk("door_floor", cur_floor, 10);
    chk("door_idle_moving", moving, 0);

    // Reset mid-move in a 3->4 segment
    rst = 1'b1;
    tick(2'b00);
    rst = 1'b0;
    chk("rst2_floor", cur_floor, 0);
    tick(2'b01);
    for (int f = 1; f <= 3; f++) begin
      for (int i = 1; i <= 7; i++) tick(2'b01);
      tick((f == 3) ? 2'b00 : 2'b01);
    end
    chk("mid_floor3", cur_floor, 3);
    chk("mid_idle", moving, 0);
    tick(2'b01);
    chk("mid_start", moving, 1);
    tick(2'b01);
    tick(2'b01);
    tick(2'b01);
    rst = 1'b1;
    tick(2'b01);
    rst = 1'b0;
    chk("mid_rst_floor", cur_floor, 0);
    chk("mid_rst_moving", moving, 0);
    chk("mid_rst_arrived", arrived, 0);
    chk("mid_rst_door", door_open, 0);
    chk("mid_rst_dir", dir_up, 1);
`ifdef ELEVATOR_FLOOR_ONEHOT_EN
    chk("mid_rst_onehot", floor_onehot, 11'b00000000001);
`endif
    for (int i = 0; i < 10; i++) begin
      tick(2'b00);
      chk("post_rst_no_arrive", arrived, 0);
      chk("post_rst_floor", cur_floor, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_car_drive.md
# elevator_car_drive

Behavioural car/shaft drive for one elevator car. It consumes the 2-bit `motor_signal` command produced by `elevator_system` for that car and moves the car one floor per travel segment. It runs the door open/hold/close timing and reports the car's position and status back to the controller. One instance is used per car; four instances close the loop around `elevator_system` in system-level simulation.

## Interface
Parameters:
- `NUM_FLOORS`, 11, number of floors, 0 .. NUM_FLOORS-1.
- `FLOOR_W`, 4, width of the floor index, at least clog2(NUM_FLOORS).
- `TRAVEL_CYCLES`, 8, clock cycles per one-floor segment, ≥ 2.
- `DOOR_CYCLES`, 16, clock cycles the door stays open, ≥ 2.
- `RESET_FLOOR`, 0, floor loaded at reset.

Ports:
- `clk`, in, 1, single clock. Rising edge.
- `rst`, in, 1, synchronous active-high reset.
- `motor_signal`, in, 2, car command: 00 stop, 01 up, 10 down, 11 open door.
- `cur_floor`, out, FLOOR_W, current floor. Registered.
- `moving`, out, 1, car is inside a travel segment.
- `dir_up`, out, 1, direction of the current or last segment (1 = up).
- `arrived`, out, 1, one-cycle pulse when `cur_floor` changes.
- `door_open`, out, 1, door is open.
- `limit_fault`, out, 1, one-cycle pulse when a move would leave the shaft.
- `floor_onehot`, out, NUM_FLOORS, present only with `ELEVATOR_FLOOR_ONEHOT_EN` (see Configuration).

## Operation
- FSM states: IDLE, MOVE, DOOR. A 16-bit-or-narrower down-counter `cnt` is shared by MOVE and DOOR.

IDLE (`motor_signal` is sampled every edge):
- 01 with `cur_floor` < NUM_FLOORS-1: go to MOVE, set `dir_up`=1, load `cnt`=TRAVEL_CYCLES-1.
- 10 with `cur_floor` > 0: go to MOVE, set `dir_up`=0, load `cnt`=TRAVEL_CYCLES-1.
- 01 at the top floor, or 10 at floor 0: pulse `limit_fault`, stay in IDLE, keep `dir_up` unchanged.
- 11: go to DOOR, load `cnt`=DOOR_CYCLES-1.
- 00: stay in IDLE.

MOVE:
- The command is ignored while `cnt`>0. A segment always completes and never reverses mid-shaft.
- Each cycle with `cnt`>0, decrement `cnt`.
- When `cnt`==0, on the next edge: `cur_floor` ±1 and `arrived`=1. Then check the new floor and the command sampled at that edge:
  - Same direction, and the new floor is not the limit in that direction: stay in MOVE and reload `cnt`=TRAVEL_CYCLES-1. The car runs through without stopping.
  - Anything else: go to IDLE.
- Reversing therefore costs at least one IDLE cycle. A same-direction command at the limit just stops, with no fault.

DOOR:
- `door_open`=1. The door can never be open while `moving`=1.
- 11 sampled in DOOR reloads `cnt`=DOOR_CYCLES-1 (door hold).
- Each other cycle with `cnt`>0, decrement `cnt`.
- When `cnt`==0 and the command is not 11: go to IDLE. Movement commands are ignored in DOOR.

Floor arithmetic:
- Unsigned FLOOR_W.
- No wrap is possible, because the IDLE and continuation checks guard both ends.

## Timing
- All outputs are registered.
- Reset values: `cur_floor`=RESET_FLOOR, `moving`=0, `dir_up`=1, `arrived`=0, `door_open`=0, `limit_fault`=0, `floor_onehot`=1<<RESET_FLOOR. State is IDLE and `cnt`=0.
- `rst` takes priority over every command. A reset mid-segment or mid-door snaps the car to RESET_FLOOR with the door closed, on the same edge.
- Move start: command 01 or 10 sampled at edge E0 in IDLE gives `moving`=1 after E0.
- Arrival: after edge E0+TRAVEL_CYCLES, `cur_floor` is updated and `arrived`=1 for exactly one cycle. `moving` falls at that same edge unless the car continues.
- Door: 11 sampled at edge E0 gives `door_open`=1 after E0. `door_open` falls after edge E0+DOOR_CYCLES if no further 11 is seen.
- `limit_fault` is asserted for one cycle, after the edge that sampled the offending command.
- After returning to IDLE, the first new command is sampled on the following edge.

## Configuration
- `ELEVATOR_FLOOR_ONEHOT_EN` defined:
  - Adds output `floor_onehot[NUM_FLOORS-1:0]` = 1<<`cur_floor`, registered and updated on the same edge as `cur_floor`.
  - The bit ordering matches `req_in_lift*`, so bit i means floor i.
- Not defined: the port and its register are absent. All other behaviour is identical.

## Test plan
- Reset check:
  - Stimulus: `rst`=1 for one edge with `motor_signal`=00.
  - Required: `cur_floor`=0, `moving`=0, `door_open`=0, `arrived`=0, `limit_fault`=0. `floor_onehot`=11'b00000000001 when enabled.
- Single floor up:
  - Stimulus: 01 applied at E0, then 00 from E1.
  - Required: `moving`=1 for 8 cycles. `cur_floor` goes 0→1 with `arrived` pulsed once after E8. Then IDLE.
- Run-through up:
  - Stimulus: 01 held from floor 0.
  - Required: `cur_floor` steps 1,2,…,10, one floor every 8 cycles, with `moving` high continuously. The car stops at 10 with no fault. A further 01 then gives a one-cycle `limit_fault` and the floor stays 10.
- Down limit and reversal:
  - Stimulus: at floor 0, command 10, then 01 applied mid-segment.
  - Required: the 10 at floor 0 pulses `limit_fault`. The 01 applied mid-segment is ignored until the segment completes, and the car returns to IDLE for at least one cycle before moving up.
- Door hold:
  - Stimulus: 11 for one cycle, 11 again at cycle 10, 01 asserted during the door phase.
  - Required: `door_open` stays high until 16 cycles after the second 11. `moving` stays 0 throughout.
- Reset mid-move:
  - Stimulus: `rst` asserted at cycle 4 of a 3→4 segment.
  - Required: next cycle `cur_floor`=0, `moving`=0, and no `arrived` pulse.
